// File: rtl/move_cmd_sequencer_if.sv
// Link between the move command sequencer and RemoteComm: the command word with
// its send strobe out, and transmit-complete plus the response byte back.
interface move_cmd_sequencer_if #(
    parameter int unsigned CMD_W  = 16,
    parameter int unsigned RESP_W = 8
);
    logic [CMD_W-1:0]  cmd;
    logic              snd_cmd;
    logic              cmd_snt;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp;

    modport master (
        output cmd,
        output snd_cmd,
        input  cmd_snt,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  snd_cmd,
        output cmd_snt,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/move_cmd_sequencer.sv
// Move command sequencer: queues Knight commands from a host loader, then plays
// them one at a time to RemoteComm, checking every response against ACK_VAL.
// Stops with a sticky error on send timeout, NAK, response timeout or abort.
// Optional macro SEQ_RETRY_EN: a failed command is re-issued up to MAX_RETRY
// times before giving up, and a retry_cnt output reports total retries.
module move_cmd_sequencer #(
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       CMD_W        = 16,
    parameter int unsigned       RESP_W       = 8,
    parameter logic [RESP_W-1:0] ACK_VAL      = RESP_W'(8'hA5),
    parameter int unsigned       TIMEOUT_CLKS = 1000000,
    parameter int unsigned       MAX_RETRY    = 2,
    localparam int unsigned      PTR_W        = $clog2(DEPTH),
    localparam int unsigned      CNT_W        = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [CMD_W-1:0]     wr_cmd,
    input  logic                 start,
    input  logic                 abort,
    move_cmd_sequencer_if.master rc,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
`ifdef SEQ_RETRY_EN
    output logic [1:0]           err_code,
    output logic [1:0]           retry_cnt,
`else
    output logic [1:0]           err_code,
`endif
    output logic [CNT_W-1:0]     cmds_done
);

`ifdef SEQ_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif
    // With retries disabled the limit is zero, so every failure is final.
    localparam int unsigned RetryLimit = RetryEn ? MAX_RETRY : 0;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitSnt,
        StWaitResp,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [CMD_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [31:0]       timer_q, timer_d;
    logic              done_q, err_q;
    logic [1:0]        err_code_q;
    logic [CNT_W-1:0]  cmds_done_q;
    logic [7:0]        try_q;

    logic              busy_s, timeout, retry_ok;
    logic              push, pop, run_clr, fail, enter_err;
    logic [1:0]        fail_code;

    assign busy_s    = (state_q == StIssue) || (state_q == StWaitSnt) || (state_q == StWaitResp);
    assign timeout   = (timer_q == TIMEOUT_CLKS - 1);
    assign retry_ok  = (32'(try_q) < RetryLimit);
    assign enter_err = (state_d == StErr) && (state_q != StErr);

    // Next-state decode; abort overrides every other event in a busy state.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        pop       = 1'b0;
        run_clr   = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        unique case (state_q)
            StIdle: begin
                push = wr_en && !full;
                if (start) begin
                    run_clr = 1'b1;
                    state_d = (count_q != '0) ? StIssue : StDone;
                end
            end
            StIssue: state_d = StWaitSnt;
            StWaitSnt: begin
                if (rc.cmd_snt) begin
                    state_d = StWaitResp;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            StWaitResp: begin
                if (rc.resp_rdy) begin
                    if (rc.resp == ACK_VAL) begin
                        pop     = 1'b1;
                        state_d = (count_q == CNT_W'(1)) ? StDone : StIssue;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
                    end
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fail) begin
            state_d = retry_ok ? StIssue : StErr;
        end
        if (abort && busy_s) begin
            state_d = StErr;
            pop     = 1'b0;
            fail    = 1'b0;
        end
    end

    // Wait timer restarts on every state change and counts only while waiting.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == StWaitSnt) || (state_q == StWaitResp)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // State, queue pointers and run status; entering the error state flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            cmds_done_q <= '0;
            try_q       <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (enter_err) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            if (state_q == StIssue) cmd_q <= mem_q[rd_ptr_q];
            if (run_clr) begin
                done_q      <= 1'b0;
                err_q       <= 1'b0;
                err_code_q  <= 2'd0;
                cmds_done_q <= '0;
                try_q       <= '0;
            end
            if (state_q == StDone) done_q <= 1'b1;
            if (enter_err) begin
                err_q <= 1'b1;
                if (fail) err_code_q <= fail_code;
            end
            if (pop) begin
                cmds_done_q <= cmds_done_q + 1'b1;
                try_q       <= '0;
            end else if (fail && retry_ok) begin
                try_q <= try_q + 8'd1;
            end
        end
    end

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= wr_cmd;
    end

`ifdef SEQ_RETRY_EN
    logic [1:0] retry_cnt_q;

    // Total retries in the current run, saturating at 3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_cnt_q <= 2'd0;
        end else if (run_clr) begin
            retry_cnt_q <= 2'd0;
        end else if (fail && retry_ok && (retry_cnt_q != 2'd3)) begin
            retry_cnt_q <= retry_cnt_q + 2'd1;
        end
    end

    assign retry_cnt = retry_cnt_q;
`endif

    // The head is shown live while issuing so cmd is valid alongside snd_cmd.
    assign rc.cmd     = (state_q == StIssue) ? mem_q[rd_ptr_q] : cmd_q;
    assign rc.snd_cmd = (state_q == StIssue);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign busy       = busy_s;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign cmds_done  = cmds_done_q;

endmodule

// File: tb/tb_move_cmd_sequencer.sv
// Bench for move_cmd_sequencer: directed scenarios, a queue-based reference
// model compared every cycle, and literal expectations for key results.
`timescale 1ns/1ps
module tb_move_cmd_sequencer;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned TO        = 1000;
    localparam int unsigned MAX_RETRY = 2;
    localparam logic [7:0]  ACK       = 8'hA5;
    localparam logic [7:0]  NAK       = 8'h5A;
    localparam logic [15:0] CAL_GYRO  = 16'h2000;
`ifdef SEQ_RETRY_EN
    localparam int NakRounds = MAX_RETRY + 1;
    localparam int ToCycles  = TO * (MAX_RETRY + 1) + MAX_RETRY;
`else
    localparam int NakRounds = 1;
    localparam int ToCycles  = TO;
`endif

    logic        clk, rst_n, wr_en, start, abort;
    logic [15:0] wr_cmd;
    logic        full, busy, done, err;
    logic [4:0]  count, cmds_done;
    logic [1:0]  err_code;
`ifdef SEQ_RETRY_EN
    logic [1:0]  retry_cnt;
`endif

    move_cmd_sequencer_if #(.CMD_W(16), .RESP_W(8)) rc_if ();

    move_cmd_sequencer #(
        .DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .ACK_VAL(ACK),
        .TIMEOUT_CLKS(TO), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd), .start(start),
        .abort(abort), .rc(rc_if), .full(full), .count(count), .busy(busy),
        .done(done), .err(err), .err_code(err_code),
`ifdef SEQ_RETRY_EN
        .retry_cnt(retry_cnt),
`endif
        .cmds_done(cmds_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int snd_total = 0;
    logic [15:0] sent [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 issuing, 2 awaiting cmd_snt, 3 awaiting response, 4 done, 5 error.
    logic [15:0] mq [$];
    int          m_ph, m_el, m_acked, m_try, m_rtot;
    logic        m_done, m_err, m_live = 1'b0;
    logic [1:0]  m_code;
    logic [15:0] m_cmd;

    always @(posedge clk) begin : model
        int sz, nxt;
        logic failed;
        logic [1:0] why;
        if (!rst_n) begin
            mq.delete();
            m_ph = 0; m_el = 0; m_acked = 0; m_try = 0; m_rtot = 0;
            m_done = 0; m_err = 0; m_code = 0; m_cmd = '0; m_live = 1'b1;
        end else begin
            sz = mq.size(); nxt = m_ph; failed = 0; why = 0;
            if (m_ph == 1) m_cmd = mq[0];
            if (abort && m_ph >= 1 && m_ph <= 3) begin
                m_err = 1; mq.delete(); nxt = 5;
            end else begin
                case (m_ph)
                    0: begin
                        if (start) begin
                            m_done = 0; m_err = 0; m_code = 0; m_acked = 0; m_try = 0; m_rtot = 0;
                            nxt = (sz > 0) ? 1 : 4;
                        end
                        if (wr_en && sz < DEPTH) mq.push_back(wr_cmd);
                    end
                    1: nxt = 2;
                    2: begin
                        if (rc_if.cmd_snt) nxt = 3;
                        else if (m_el + 1 == TO) begin failed = 1; why = 1; end
                    end
                    3: begin
                        if (rc_if.resp_rdy && rc_if.resp == ACK) begin
                            void'(mq.pop_front());
                            m_acked++; m_try = 0;
                            nxt = (mq.size() == 0) ? 4 : 1;
                        end else if (rc_if.resp_rdy) begin
                            failed = 1; why = 2;
                        end else if (m_el + 1 == TO) begin
                            failed = 1; why = 3;
                        end
                    end
                    4: begin m_done = 1; nxt = 0; end
                    default: nxt = 0;
                endcase
                if (failed) begin
`ifdef SEQ_RETRY_EN
                    if (m_try < MAX_RETRY) begin
                        m_try++;
                        if (m_rtot < 3) m_rtot++;
                        nxt = 1;
                    end else begin
                        m_err = 1; m_code = why; mq.delete(); nxt = 5;
                    end
`else
                    m_err = 1; m_code = why; mq.delete(); nxt = 5;
`endif
                end
            end
            if (nxt != m_ph) m_el = 0;
            else if (m_ph == 2 || m_ph == 3) m_el++;
            m_ph = nxt;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin : compare
        logic [15:0] ec;
        if (m_live) begin
            ec = m_cmd;
            if (m_ph == 1) ec = mq[0];
            chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
            chk("snd_cmd", 32'(rc_if.snd_cmd), 32'(m_ph == 1));
            chk("cmd", 32'(rc_if.cmd), 32'(ec));
            chk("count", 32'(count), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("cmds_done", 32'(cmds_done), 32'(m_acked));
`ifdef SEQ_RETRY_EN
            chk("retry_cnt", 32'(retry_cnt), 32'(m_rtot));
`endif
        end
    end

    // Log of every command handed to RemoteComm.
    always @(negedge clk) begin
        if (rc_if.snd_cmd === 1'b1) begin
            sent.push_back(rc_if.cmd);
            snd_total++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [15:0] c);
        wr_en = 1'b1; wr_cmd = c; tick(); wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    endtask

    task automatic wait_snd();
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (rc_if.snd_cmd) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_snd: snd_cmd absent for 64 cycles, expected a pulse");
        end
    endtask

    // Plays RemoteComm for one command: transmit complete, then the response byte.
    task automatic serve(input logic [7:0] r);
        wait_snd();
        tick(); tick();
        rc_if.cmd_snt = 1'b1; tick(); rc_if.cmd_snt = 1'b0;
        tick(); tick();
        rc_if.resp = r; rc_if.resp_rdy = 1'b1; tick();
        rc_if.resp_rdy = 1'b0; rc_if.resp = '0;
    endtask

    task automatic settle();
        bit idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            tick();
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL settle: busy stuck at 1 for 200 cycles, expected 0");
        end
        repeat (3) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"}, 32'(rc_if.cmd), 32'h0);
        chk({tag, "_snd"}, 32'(rc_if.snd_cmd), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_code"}, 32'(err_code), 32'h0);
        chk({tag, "_cmds"}, 32'(cmds_done), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_full"}, 32'(full), 32'h0);
    endtask

    initial begin : main
        logic [15:0] exp1 [3];
        int n, sn;
        rst_n = 1'b0; wr_en = 1'b0; wr_cmd = '0; start = 1'b0; abort = 1'b0;
        rc_if.cmd_snt = 1'b0; rc_if.resp_rdy = 1'b0; rc_if.resp = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst_n = 1'b1; tick();

        // Three commands, all acknowledged.
        exp1[0] = CAL_GYRO; exp1[1] = 16'h4BF1; exp1[2] = 16'h57F2;
        sent.delete();
        for (int i = 0; i < 3; i++) push(exp1[i]);
        go();
        for (int i = 0; i < 3; i++) serve(ACK);
        settle();
        chk("t1_nsent", 32'(sent.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < sent.size()) chk("t1_cmd_order", 32'(sent[i]), 32'(exp1[i]));
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_cmds_done", 32'(cmds_done), 32'd3);
        chk("t1_count", 32'(count), 32'd0);

        // Second command NAKed.
        push(16'h4BF1); push(16'h47F1);
        go();
        serve(ACK);
        for (int i = 0; i < NakRounds; i++) serve(NAK);
        settle();
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_err_code", 32'(err_code), 32'd2);
        chk("t2_cmds_done", 32'(cmds_done), 32'd1);
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_done", 32'(done), 32'd0);
`ifdef SEQ_RETRY_EN
        chk("t2_retry_cnt", 32'(retry_cnt), 32'd2);
`endif

        // cmd_snt never arrives: send timeout.
        push(16'h4BF1);
        go();
        wait_snd();
        @(posedge clk);
        n = 0;
        for (int i = 0; i < ToCycles + 50; i++) begin
            @(negedge clk);
            if (err) break;
            n++;
        end
        chk("t3_timeout_clks", 32'(n), 32'(ToCycles));
        chk("t3_err_code", 32'(err_code), 32'd1);
        settle();

        // Overfill, then writes while busy.
        reset_dut();
        for (int i = 0; i < DEPTH + 1; i++) push(16'h1000 + 16'(i));
        chk("t4_count_full", 32'(count), 32'(DEPTH));
        chk("t4_full", 32'(full), 32'd1);
        reset_dut();
        push(16'h4BF1);
        go();
        wr_en = 1'b1; wr_cmd = 16'hBEEF;
        serve(ACK);
        wr_en = 1'b0;
        settle();
        chk("t4_busy_write_dropped", 32'(count), 32'd0);
        chk("t4_cmds_done", 32'(cmds_done), 32'd1);

        // Empty start completes two clocks later with no send.
        sn = snd_total;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_done_after_1clk", 32'(done), 32'd0);
        tick();
        chk("t5_done_after_2clk", 32'(done), 32'd1);
        chk("t5_empty_cmds_done", 32'(cmds_done), 32'd0);
        chk("t5_empty_no_snd", 32'(snd_total), 32'(sn));
        settle();

        // Abort while waiting for the response.
        push(16'h4BF1); push(16'h57F2);
        go();
        wait_snd();
        tick(); tick();
        rc_if.cmd_snt = 1'b1; tick(); rc_if.cmd_snt = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_err", 32'(err), 32'd1);
        chk("t5_abort_code", 32'(err_code), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_count", 32'(count), 32'd0);
        settle();

        // Reset in the middle of a run.
        push(16'h4BF1); push(16'h57F2); push(CAL_GYRO);
        go();
        wait_snd();
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk_reset_vals("t5_midrst");
        sn = snd_total;
        repeat (20) tick();
        chk("t5_no_snd_after_rst", 32'(snd_total), 32'(sn));

`ifdef SEQ_RETRY_EN
        // NAK then ACK: the same command is re-sent.
        sent.delete();
        push(16'h57F2);
        go();
        serve(NAK);
        serve(ACK);
        settle();
        chk("t6_nsent", 32'(sent.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (i < sent.size()) chk("t6_resent_cmd", 32'(sent[i]), 32'h57F2);
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_retry_cnt", 32'(retry_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
